// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Bit-counter width for a given word width; never below one bit.
    function automatic int piso_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry word buffer that lets the next word wait while the current one shifts out.
module piso_hold_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (wr_en_i && !full_q) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load side and a one-word hold buffer.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int               CNT_W    = piso_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;

    logic             hold_full, hold_wr, hold_pop;
    logic [WIDTH-1:0] hold_data;
    logic             accept;
    logic             load_now;
    logic [WIDTH-1:0] load_word;

    assign load_ready = !hold_full && !rst;
    assign accept     = load_valid && load_ready;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // The shift register keeps only the bits still to be sent, next one at the exit end.
    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (hold_wr),
        .wr_data_i (load_data),
        .pop_i     (hold_pop),
        .full_o    (hold_full),
        .data_o    (hold_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        hold_wr       = 1'b0;
        hold_pop      = 1'b0;
        load_now      = 1'b0;
        load_word     = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_now  = 1'b1;
                    load_word = load_data;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    ser_out_d   = first_bit(shreg_q);
                    shreg_d     = drop_first(shreg_q);
                    ser_valid_d = 1'b1;
                    hold_wr     = accept;
                end else if (hold_full) begin
                    load_now  = 1'b1;
                    load_word = hold_data;
                    hold_pop  = 1'b1;
                end else if (accept) begin
                    load_now  = 1'b1;
                    load_word = load_data;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_now) begin
            cnt_d         = '0;
            ser_out_d     = first_bit(load_word);
            shreg_d       = drop_first(load_word);
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = ser_valid_q | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: WIDTH=4 MSB-first instance and WIDTH=5 LSB-first instance.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_lv, a_lr, a_so, a_sv, a_fs, a_busy;
    logic [3:0] a_ld;
    logic       b_lv, b_lr, b_so, b_sv, b_fs, b_busy;
    logic [4:0] b_ld;

    int n_total = 0;
    int n_bad   = 0;
    bit rec     = 1'b0;

    logic a_so_q[$], a_sv_q[$], a_fs_q[$], a_lr_q[$], a_busy_q[$];
    logic b_so_q[$], b_sv_q[$], b_fs_q[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .load_valid(a_lv), .load_ready(a_lr), .load_data(a_ld),
        .ser_out(a_so), .ser_valid(a_sv), .frame_start(a_fs), .busy(a_busy)
    );

    piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .load_valid(b_lv), .load_ready(b_lr), .load_data(b_ld),
        .ser_out(b_so), .ser_valid(b_sv), .frame_start(b_fs), .busy(b_busy)
    );

    // Cycle-value monitor: one sample per cycle, mid-cycle.
    always @(negedge clk) begin
        if (rec) begin
            a_so_q.push_back(a_so);
            a_sv_q.push_back(a_sv);
            a_fs_q.push_back(a_fs);
            a_lr_q.push_back(a_lr);
            a_busy_q.push_back(a_busy);
            b_so_q.push_back(b_so);
            b_sv_q.push_back(b_sv);
            b_fs_q.push_back(b_fs);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        a_so_q.delete(); a_sv_q.delete(); a_fs_q.delete(); a_lr_q.delete(); a_busy_q.delete();
        b_so_q.delete(); b_sv_q.delete(); b_fs_q.delete();
    endtask

    // Present one word for one edge, then record ncyc cycles starting at cycle 1.
    task automatic send_capture(input bit sel_b, input logic [4:0] word, input int ncyc);
        if (sel_b) begin
            b_lv = 1'b1;
            b_ld = word;
        end else begin
            a_lv = 1'b1;
            a_ld = word[3:0];
        end
        step();
        a_lv = 1'b0;
        b_lv = 1'b0;
        clear_rec();
        rec = 1'b1;
        repeat (ncyc) step();
        rec = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  rx;
        logic [3:0]  w4;
        logic [4:0]  w5;
        logic [7:0]  s8;
        logic [11:0] s12;
        int          acc_e[$];
        int          widx;
        bit          acc;

        // Reset with load_valid asserted
        rst = 1'b1; a_lv = 1'b1; a_ld = 4'hF; b_lv = 1'b1; b_ld = 5'h1F;
        #1;
        check_eq("rst_ready_pre", a_lr, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq($sformatf("rst%0d_ser_valid", i), a_sv, 1'b0);
            check_eq($sformatf("rst%0d_ser_out", i), a_so, 1'b0);
            check_eq($sformatf("rst%0d_frame_start", i), a_fs, 1'b0);
            check_eq($sformatf("rst%0d_busy", i), a_busy, 1'b0);
            check_eq($sformatf("rst%0d_ready", i), a_lr, 1'b0);
            check_eq($sformatf("rst%0d_b_ready", i), b_lr, 1'b0);
        end
        rst = 1'b0; a_lv = 1'b0; b_lv = 1'b0;
        #1;
        check_eq("rst_release_ready", a_lr, 1'b1);
        step();
        check_eq("rst_release_ser_valid", a_sv, 1'b0);
        check_eq("rst_release_busy", a_busy, 1'b0);

        // Single word 4'b1011 with a 4-stage receiver
        w4 = 4'b1011;
        send_capture(1'b0, 5'(w4), 5);
        rx = '0;
        for (int c = 1; c <= 4; c++) begin
            check_eq($sformatf("single_c%0d_out", c), a_so_q[c-1], w4[4-c]);
            check_eq($sformatf("single_c%0d_valid", c), a_sv_q[c-1], 1'b1);
            check_eq($sformatf("single_c%0d_fs", c), a_fs_q[c-1], (c == 1));
            rx = {rx[2:0], a_so_q[c-1]};
        end
        check_eq("single_c5_valid", a_sv_q[4], 1'b0);
        check_eq("single_rx_word", rx, 4'b1011);

        // Back-to-back 4'hA then 4'h5
        step();
        a_lv = 1'b1; a_ld = 4'hA;
        step();
        clear_rec(); rec = 1'b1;
        a_ld = 4'h5;
        step();
        a_lv = 1'b0;
        repeat (8) step();
        rec = 1'b0;
        s8 = 8'hA5;
        for (int c = 1; c <= 8; c++) begin
            check_eq($sformatf("b2b_c%0d_out", c), a_so_q[c-1], s8[8-c]);
            check_eq($sformatf("b2b_c%0d_valid", c), a_sv_q[c-1], 1'b1);
            check_eq($sformatf("b2b_c%0d_fs", c), a_fs_q[c-1], (c == 1 || c == 5));
        end
        check_eq("b2b_c9_valid", a_sv_q[8], 1'b0);
        for (int c = 2; c <= 4; c++) begin
            check_eq($sformatf("b2b_c%0d_ready", c), a_lr_q[c-1], 1'b0);
        end
        check_eq("b2b_c5_ready", a_lr_q[4], 1'b1);

        // Backpressure: 1, 2, 3 offered continuously
        step();
        a_lv = 1'b1; a_ld = 4'h1; widx = 0;
        for (int e = 0; e < 14; e++) begin
            acc = a_lv && a_lr;
            step();
            if (e == 0) begin
                clear_rec();
                rec = 1'b1;
            end
            if (acc) begin
                acc_e.push_back(e);
                widx++;
                if (widx == 3) a_lv = 1'b0;
                else a_ld = 4'(widx + 1);
            end
        end
        rec = 1'b0;
        check_eq("bp_accept_count", acc_e.size(), 3);
        check_eq("bp_accept0_edge", acc_e[0], 0);
        check_eq("bp_accept1_edge", acc_e[1], 1);
        check_eq("bp_accept2_edge", acc_e[2], 5);
        s12 = 12'h123;
        for (int c = 1; c <= 12; c++) begin
            check_eq($sformatf("bp_c%0d_out", c), a_so_q[c-1], s12[12-c]);
            check_eq($sformatf("bp_c%0d_valid", c), a_sv_q[c-1], 1'b1);
        end
        check_eq("bp_c13_valid", a_sv_q[12], 1'b0);

        // Reset during the third bit of 4'hF with 4'hC held
        step();
        a_lv = 1'b1; a_ld = 4'hF;
        step();
        clear_rec(); rec = 1'b1;
        a_ld = 4'hC;
        step();
        a_lv = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        rec = 1'b0;
        check_eq("mid_c3_out", a_so_q[2], 1'b1);
        check_eq("mid_c3_valid", a_sv_q[2], 1'b1);
        check_eq("mid_c3_busy", a_busy_q[2], 1'b1);
        check_eq("mid_c3_ready", a_lr_q[2], 1'b0);
        for (int c = 4; c <= 8; c++) begin
            check_eq($sformatf("mid_c%0d_valid", c), a_sv_q[c-1], 1'b0);
            check_eq($sformatf("mid_c%0d_busy", c), a_busy_q[c-1], 1'b0);
        end
        w4 = 4'h9;
        send_capture(1'b0, 5'(w4), 5);
        for (int c = 1; c <= 4; c++) begin
            check_eq($sformatf("after_rst_c%0d_out", c), a_so_q[c-1], w4[4-c]);
            check_eq($sformatf("after_rst_c%0d_valid", c), a_sv_q[c-1], 1'b1);
            check_eq($sformatf("after_rst_c%0d_fs", c), a_fs_q[c-1], (c == 1));
        end
        check_eq("after_rst_c5_valid", a_sv_q[4], 1'b0);

        // LSB-first, WIDTH=5
        w5 = 5'b00011;
        send_capture(1'b1, w5, 7);
        for (int c = 1; c <= 5; c++) begin
            check_eq($sformatf("lsb_c%0d_out", c), b_so_q[c-1], w5[c-1]);
            check_eq($sformatf("lsb_c%0d_valid", c), b_sv_q[c-1], 1'b1);
            check_eq($sformatf("lsb_c%0d_fs", c), b_fs_q[c-1], (c == 1));
        end
        check_eq("lsb_c6_valid", b_sv_q[5], 1'b0);
        check_eq("lsb_c7_valid", b_sv_q[6], 1'b0);
        check_eq("lsb_idle_busy", b_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock with a serial valid and a word-start marker. Sits in front of the team's serial-in shift-register receivers: with MSB_FIRST=1, a WIDTH-stage receiver that shifts into stage 0 holds the original word after WIDTH cycles. A one-entry hold buffer lets consecutive words stream without gaps.

## Interface
- WIDTH, 4: word width in bits; must be at least 2.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- load_valid  input  1  load_data is presented.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialize.
- ser_out  output  1  serial data bit, registered.
- ser_valid  output  1  ser_out carries a valid bit, registered.
- frame_start  output  1  high with the first bit of each word, registered.
- busy  output  1  ser_valid OR hold buffer full.

## Operation
- **Transfer rule:** a word is accepted on a rising edge where load_valid and load_ready are both 1.
- **load_ready:** equals NOT hold_full AND NOT rst. It is combinational from registered state and rst, with no path from load_valid.
- **State machine (2 states):**
  - **IDLE.** An accepted word loads directly into the shift register, the bit counter is set to 0, and the state goes to SHIFT. The hold buffer stays empty.
  - **SHIFT with counter below WIDTH-1.** The next bit is output and the counter increments. An accepted word goes into the hold buffer and hold_full is set.
  - **SHIFT with counter at WIDTH-1 (last bit).** Priority order:
    1. If hold_full is set, the hold contents move to the shift register, the counter goes to 0, and hold_full clears.
    2. Otherwise, if a word is accepted on this edge, it loads directly into the shift register and the counter goes to 0.
    3. Otherwise, the state goes to IDLE.
- **Bit order:** with MSB_FIRST=1, the bit sent at counter value k is word bit WIDTH-1-k. With MSB_FIRST=0, it is word bit k.
- **Counter:** width $clog2(WIDTH). Wrap is explicit, at WIDTH-1, never by overflow. Non-power-of-two WIDTH is supported.
- **Idle outputs:** ser_out=0, ser_valid=0, frame_start=0.
- **Reset** (any cycle, including mid-word or with the hold buffer full):
  - The state goes to IDLE; the counter, shift register, hold buffer and hold_full all clear.
  - The partially sent word and any held word are discarded without notice.
  - A handshake coinciding with rst high is not a transfer, because load_ready is 0.

## Timing
- **Reset values:** ser_out=0, ser_valid=0, frame_start=0, busy=0. load_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- **Latency:** a word accepted at edge N drives its first bit on ser_out in cycle N+1, and its last bit in cycle N+WIDTH.
- **Throughput:** one word per WIDTH cycles sustained. There is no idle cycle between consecutive words when the next word is held, or is accepted on or before the last-bit edge.
- **Backpressure:** load_ready is low from the cycle after the hold buffer fills until the cycle after it drains.
- **frame_start:** exactly one cycle per word, coincident with that word's first bit.

## Structure
- **Package piso_pkg:** state enum typedef (IDLE, SHIFT) and a function returning the counter width for a given WIDTH.
- **Sub-module piso_hold_buf:** a one-entry, WIDTH-bit buffer with ports for write, read-pop, full and data. The top level holds the FSM, counter and shift register.

## Test plan
All scenarios use WIDTH=4 unless noted.

1. **Reset:** rst high for 2 cycles with load_valid=1 -> ser_valid=0, ser_out=0, frame_start=0, busy=0 and load_ready=0 throughout; load_ready=1 in the cycle after rst falls; nothing is serialized.
2. **Single word:** 4'b1011 accepted at edge N (MSB_FIRST=1) -> ser_out is 1,0,1,1 in cycles N+1..N+4 with ser_valid=1, frame_start=1 only in N+1, ser_valid=0 in N+5. A 4-stage serial-in shift register fed by ser_out holds 4'b1011 after cycle N+4.
3. **Back-to-back:** 4'hA accepted at edge 0, then 4'h5 at edge 1 -> ser_out is 1,0,1,0,0,1,0,1 in cycles 1..8 with no gap; frame_start in cycles 1 and 5; load_ready=0 in cycles 2..4 and 1 in cycle 5.
4. **Backpressure:** load_valid held with words 4'h1, 4'h2, 4'h3 -> accepted at edges 0, 1 and 5; ser_valid continuous for cycles 1..12; the serial stream reproduces the three words in order.
5. **Reset mid-operation:** rst asserted during the third bit of 4'hF while 4'hC is held -> ser_valid=0 from the next cycle; 4'hC is never emitted. A subsequent 4'h9 serializes as 1,0,0,1 with frame_start on its first bit.
6. **LSB-first:** MSB_FIRST=0, WIDTH=5, word 5'b00011 -> ser_out is 1,1,0,0,0; the counter wraps after 5 bits and the block returns to idle.
